// File: rtl/icache_sa_nb.sv
// Non-blocking set-associative instruction cache with a merging miss table,
// round-robin replacement and epoch-tagged invalidation.
module icache_sa_nb #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_WAYS     = 4,
  parameter int unsigned NUM_SETS     = 32,
  parameter int unsigned BLOCK_WORDS  = 8,
  parameter int unsigned NUM_FETCH    = 2,
  parameter int unsigned NUM_WARPS    = 8,
  parameter int unsigned MISS_ENTRIES = 4,
  localparam int unsigned WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int unsigned SRC_W = (MISS_ENTRIES > 1) ? $clog2(MISS_ENTRIES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          invalid_i,
  input  logic                          core_req_valid_i,
  output logic                          core_req_ready_o,
  input  logic [XLEN-1:0]               core_req_addr_i,
  input  logic [NUM_FETCH-1:0]          core_req_mask_i,
  input  logic [WID_W-1:0]              core_req_wid_i,
  input  logic                          flush_valid_i,
  input  logic [WID_W-1:0]              flush_wid_i,
  output logic                          core_rsp_valid_o,
  output logic [XLEN-1:0]               core_rsp_addr_o,
  output logic [NUM_FETCH*XLEN-1:0]     core_rsp_data_o,
  output logic [NUM_FETCH-1:0]          core_rsp_mask_o,
  output logic [WID_W-1:0]              core_rsp_wid_o,
  output logic                          core_rsp_status_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [XLEN-1:0]               mem_req_addr_o,
  output logic [SRC_W-1:0]              mem_req_source_o,
  input  logic                          mem_rsp_valid_i,
  output logic                          mem_rsp_ready_o,
  input  logic [SRC_W-1:0]              mem_rsp_source_i,
  input  logic [BLOCK_WORDS*XLEN-1:0]   mem_rsp_data_i
);

  localparam int unsigned WOFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned OFF_W  = WOFF_W + 2;
  localparam int unsigned SET_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W  = XLEN - OFF_W - SET_W;
  localparam int unsigned BLK_W  = XLEN - OFF_W;
  localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
  localparam int unsigned LINE_W = BLOCK_WORDS * XLEN;

  // cache arrays and replacement state
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   r_data  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [WAY_W-1:0]    r_rr    [NUM_SETS];
  logic                r_epoch;
  logic                r_rst_done;

  // miss table
  logic [MISS_ENTRIES-1:0] r_mt_valid;
  logic [MISS_ENTRIES-1:0] r_mt_issued;
  logic [MISS_ENTRIES-1:0] r_mt_epoch;
  logic [BLK_W-1:0]        r_mt_blk [MISS_ENTRIES];
  logic                    r_mq_lock;
  logic [SRC_W-1:0]        r_mq_src;

  // pipeline registers
  logic                 r_s1_valid;
  logic [XLEN-1:0]      r_s1_addr;
  logic [NUM_FETCH-1:0] r_s1_mask;
  logic [WID_W-1:0]     r_s1_wid;

  logic                      w_req_fire, w_s0_keep, w_s1_live;
  logic [SET_W-1:0]          w_s1_set;
  logic [TAG_W-1:0]          w_s1_tag;
  logic [BLK_W-1:0]          w_s1_blk;
  logic [WOFF_W-1:0]         w_s1_woff, w_word_idx;
  logic                      w_hit;
  logic [WAY_W-1:0]          w_hit_way;
  logic [LINE_W-1:0]         w_line;
  logic [NUM_FETCH*XLEN-1:0] w_rsp_data;
  logic                      w_mrsp_fire, w_rf_live, w_rf_epoch, w_refill_we;
  logic [MISS_ENTRIES-1:0]   w_rsp_hit_e, w_free_vec;
  logic [BLK_W-1:0]          w_rf_blk, w_mq_blk;
  logic [SET_W-1:0]          w_rf_set;
  logic [TAG_W-1:0]          w_rf_tag;
  logic                      w_merge, w_free_found, w_alloc, w_pend_found, w_mreq_fire;
  logic [SRC_W-1:0]          w_free_idx, w_pend_idx, w_mq_src;

  assign w_mrsp_fire      = mem_rsp_valid_i & r_rst_done;
  assign mem_rsp_ready_o  = r_rst_done;
  assign core_req_ready_o = r_rst_done & ~w_refill_we & ~invalid_i;
  assign w_req_fire       = core_req_valid_i & core_req_ready_o;
  assign w_s0_keep        = w_req_fire & ~(flush_valid_i && flush_wid_i == core_req_wid_i);
  assign w_s1_live        = r_s1_valid & ~(flush_valid_i && flush_wid_i == r_s1_wid);
  assign w_s1_set         = r_s1_addr[OFF_W +: SET_W];
  assign w_s1_tag         = r_s1_addr[XLEN-1 -: TAG_W];
  assign w_s1_blk         = r_s1_addr[XLEN-1:OFF_W];
  assign w_s1_woff        = r_s1_addr[2 +: WOFF_W];

  // reset-done flag gates both handshakes until the first clock after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_done <= 1'b0;
    else        r_rst_done <= 1'b1;
  end

  // tag compare and word selection for the request in st1
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_rsp_data = '0;
    w_word_idx = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_s1_set][w] && r_tag[w_s1_set][w] == w_s1_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    w_line = r_data[w_s1_set][w_hit_way];
    for (int unsigned i = 0; i < NUM_FETCH; i++) begin
      w_word_idx = w_s1_woff + WOFF_W'(i);
      w_rsp_data[i*XLEN +: XLEN] = w_line[w_word_idx*XLEN +: XLEN];
    end
  end

  // decode the refill source against the table without out-of-range indexing
  always_comb begin
    w_rsp_hit_e = '0;
    w_rf_blk    = '0;
    w_rf_live   = 1'b0;
    w_rf_epoch  = 1'b0;
    for (int unsigned e = 0; e < MISS_ENTRIES; e++) begin
      if (SRC_W'(e) == mem_rsp_source_i) begin
        w_rsp_hit_e[e] = 1'b1;
        w_rf_blk       = r_mt_blk[e];
        w_rf_live      = r_mt_valid[e];
        w_rf_epoch     = r_mt_epoch[e];
      end
    end
  end

  assign w_free_vec  = w_mrsp_fire ? w_rsp_hit_e : '0;
  assign w_refill_we = w_mrsp_fire & w_rf_live & (w_rf_epoch == r_epoch);
  assign w_rf_set    = w_rf_blk[SET_W-1:0];
  assign w_rf_tag    = w_rf_blk[BLK_W-1:SET_W];

  // miss-table probe: merge target, lowest free slot, lowest unissued entry
  always_comb begin
    w_merge      = 1'b0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_pend_found = 1'b0;
    w_pend_idx   = '0;
    for (int unsigned e = 0; e < MISS_ENTRIES; e++) begin
      // an entry being freed this cycle cannot absorb a new miss
      if (r_mt_valid[e] && !w_free_vec[e] && r_mt_blk[e] == w_s1_blk) w_merge = 1'b1;
      if (!r_mt_valid[e] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = SRC_W'(e);
      end
      if (r_mt_valid[e] && !r_mt_issued[e] && !w_pend_found) begin
        w_pend_found = 1'b1;
        w_pend_idx   = SRC_W'(e);
      end
    end
  end

  assign w_alloc  = w_s1_live & ~w_hit & ~w_merge & w_free_found;
  assign w_mq_src = r_mq_lock ? r_mq_src : w_pend_idx;

  // block address of the entry currently presented to memory
  always_comb begin
    w_mq_blk = '0;
    for (int unsigned e = 0; e < MISS_ENTRIES; e++)
      if (SRC_W'(e) == w_mq_src) w_mq_blk = r_mt_blk[e];
  end

  assign mem_req_valid_o  = r_mq_lock | w_pend_found;
  assign mem_req_source_o = mem_req_valid_o ? w_mq_src : '0;
  assign mem_req_addr_o   = mem_req_valid_o ? {w_mq_blk, {OFF_W{1'b0}}} : '0;
  assign w_mreq_fire      = mem_req_valid_o & mem_req_ready_i;

  // miss-table update: free on refill, mark issued on fire, allocate on miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mt_valid  <= '0;
      r_mt_issued <= '0;
      r_mt_epoch  <= '0;
      r_mq_lock   <= 1'b0;
      r_mq_src    <= '0;
      for (int unsigned e = 0; e < MISS_ENTRIES; e++) r_mt_blk[e] <= '0;
    end else begin
      for (int unsigned e = 0; e < MISS_ENTRIES; e++) begin
        if (w_free_vec[e]) begin
          r_mt_valid[e]  <= 1'b0;
          r_mt_issued[e] <= 1'b0;
        end
        if (w_mreq_fire && w_mq_src == SRC_W'(e)) r_mt_issued[e] <= 1'b1;
        if (w_alloc && w_free_idx == SRC_W'(e)) begin
          r_mt_valid[e]  <= 1'b1;
          r_mt_issued[e] <= 1'b0;
          r_mt_epoch[e]  <= r_epoch;
          r_mt_blk[e]    <= w_s1_blk;
        end
      end
      // hold the presented entry until memory takes it, even if a lower slot fills
      r_mq_lock <= mem_req_valid_o & ~mem_req_ready_i;
      r_mq_src  <= w_mq_src;
    end
  end

  // valid bits, RR pointers and epoch; invalidate overrides a same-cycle refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epoch <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if (w_refill_we) begin
        r_valid[w_rf_set][r_rr[w_rf_set]] <= 1'b1;
        r_rr[w_rf_set]                    <= r_rr[w_rf_set] + WAY_W'(1);
      end
      if (invalid_i) begin
        r_epoch <= ~r_epoch;
        for (int unsigned s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
      end
    end
  end

  // tag/data arrays are written only by refills and need no reset
  always_ff @(posedge clk) begin
    if (w_refill_we) begin
      r_tag[w_rf_set][r_rr[w_rf_set]]  <= w_rf_tag;
      r_data[w_rf_set][r_rr[w_rf_set]] <= mem_rsp_data_i;
    end
  end

  // st0 -> st1 request register; flushed requests are dropped on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_mask  <= '0;
      r_s1_wid   <= '0;
    end else begin
      r_s1_valid <= w_s0_keep;
      if (w_req_fire) begin
        r_s1_addr <= core_req_addr_i;
        r_s1_mask <= core_req_mask_i;
        r_s1_wid  <= core_req_wid_i;
      end
    end
  end

  // st1 -> st2 response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rsp_valid_o  <= 1'b0;
      core_rsp_addr_o   <= '0;
      core_rsp_data_o   <= '0;
      core_rsp_mask_o   <= '0;
      core_rsp_wid_o    <= '0;
      core_rsp_status_o <= 1'b0;
    end else begin
      core_rsp_valid_o <= w_s1_live;
      if (w_s1_live) begin
        core_rsp_addr_o   <= r_s1_addr;
        core_rsp_data_o   <= w_rsp_data;
        core_rsp_mask_o   <= r_s1_mask;
        core_rsp_wid_o    <= r_s1_wid;
        core_rsp_status_o <= ~w_hit;
      end
    end
  end

endmodule

// File: tb/tb_icache_sa_nb.sv
// Scoreboard bench for icache_sa_nb: expected responses are queued at acceptance
// and compared (including two-cycle latency) when the cache responds.
module tb_icache_sa_nb;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          invalid_i;
  logic          core_req_valid_i;
  logic          core_req_ready_o;
  logic [31:0]   core_req_addr_i;
  logic [1:0]    core_req_mask_i;
  logic [2:0]    core_req_wid_i;
  logic          flush_valid_i;
  logic [2:0]    flush_wid_i;
  logic          core_rsp_valid_o;
  logic [31:0]   core_rsp_addr_o;
  logic [63:0]   core_rsp_data_o;
  logic [1:0]    core_rsp_mask_o;
  logic [2:0]    core_rsp_wid_o;
  logic          core_rsp_status_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [31:0]   mem_req_addr_o;
  logic [1:0]    mem_req_source_o;
  logic          mem_rsp_valid_i;
  logic          mem_rsp_ready_o;
  logic [1:0]    mem_rsp_source_i;
  logic [255:0]  mem_rsp_data_i;

  icache_sa_nb #(
    .XLEN(32), .NUM_WAYS(4), .NUM_SETS(32), .BLOCK_WORDS(8),
    .NUM_FETCH(2), .NUM_WARPS(8), .MISS_ENTRIES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .invalid_i(invalid_i),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_addr_i(core_req_addr_i), .core_req_mask_i(core_req_mask_i),
    .core_req_wid_i(core_req_wid_i), .flush_valid_i(flush_valid_i),
    .flush_wid_i(flush_wid_i), .core_rsp_valid_o(core_rsp_valid_o),
    .core_rsp_addr_o(core_rsp_addr_o), .core_rsp_data_o(core_rsp_data_o),
    .core_rsp_mask_o(core_rsp_mask_o), .core_rsp_wid_o(core_rsp_wid_o),
    .core_rsp_status_o(core_rsp_status_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_source_o(mem_req_source_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_ready_o(mem_rsp_ready_o), .mem_rsp_source_i(mem_rsp_source_i),
    .mem_rsp_data_i(mem_rsp_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  wid;
    logic [1:0]  mask;
    logic        status;
    logic [63:0] data;
    int unsigned acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  src;
  } mq_t;

  exp_t        sb[$];
  mq_t         mq[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned n_mreq = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // backing memory: block 0x1000 holds 0xA0..0xA7, everything else is address-derived
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a[31:5] == 27'h80) return 32'hA0 + {29'd0, a[4:2]};
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [255:0] blockdata(input logic [31:0] b);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = memword(b + 32'(4 * i));
    return d;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // response monitor: pops the scoreboard
  exp_t e_mon;
  always @(negedge clk) begin
    if (rst_n && core_rsp_valid_o) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 64'(core_rsp_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e_mon = sb.pop_front();
        check_eq("rsp_addr",   64'(core_rsp_addr_o),   64'(e_mon.addr));
        check_eq("rsp_wid",    64'(core_rsp_wid_o),    64'(e_mon.wid));
        check_eq("rsp_mask",   64'(core_rsp_mask_o),   64'(e_mon.mask));
        check_eq("rsp_status", 64'(core_rsp_status_o), 64'(e_mon.status));
        check_eq("rsp_latency", 64'(cyc), 64'(e_mon.acc + 2));
        if (!e_mon.status) check_eq("rsp_data", core_rsp_data_o, e_mon.data);
      end
    end
  end

  // memory request capture
  always @(negedge clk) begin
    if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
      mq.push_back('{addr: mem_req_addr_o, src: mem_req_source_o});
      n_mreq++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic req(input logic [31:0] a, input logic [2:0] wid, input logic [1:0] mask,
                     input logic status);
    bit acc;
    acc = 0;
    core_req_valid_i = 1'b1;
    core_req_addr_i  = a;
    core_req_wid_i   = wid;
    core_req_mask_i  = mask;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (core_req_ready_o) begin
        sb.push_back('{addr: a, wid: wid, mask: mask, status: status,
                       data: {memword(a + 32'd4), memword(a)}, acc: cyc});
        acc = 1;
        tick();
        break;
      end
      tick();
    end
    if (!acc) check_eq("req_accept_timeout", 64'd0, 64'd1);
    core_req_valid_i = 1'b0;
  endtask

  task automatic wait_mq(input int n);
    for (int k = 0; k < 40; k++) begin
      if (mq.size() >= n) break;
      tick();
    end
    check_eq("mreq_pending", 64'(mq.size()), 64'(n));
  endtask

  task automatic refill(input bit expect_write);
    mq_t m;
    if (mq.size() == 0) begin
      check_eq("refill_no_request", 64'd0, 64'd1);
      return;
    end
    m = mq.pop_front();
    mem_rsp_valid_i  = 1'b1;
    mem_rsp_source_i = m.src;
    mem_rsp_data_i   = blockdata(m.addr);
    @(negedge clk);
    check_eq("ready_in_refill", 64'(core_req_ready_o), 64'(!expect_write));
    tick();
    mem_rsp_valid_i = 1'b0;
  endtask

  task automatic pulse_invalid();
    invalid_i = 1'b1;
    @(negedge clk);
    check_eq("ready_in_invalid", 64'(core_req_ready_o), 64'd0);
    tick();
    invalid_i = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mq_t m;
    int unsigned base;
    rst_n = 1'b0; invalid_i = 1'b0; core_req_valid_i = 1'b0; core_req_addr_i = '0;
    core_req_mask_i = '0; core_req_wid_i = '0; flush_valid_i = 1'b0; flush_wid_i = '0;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_source_i = '0; mem_rsp_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready",  64'(core_req_ready_o), 64'd0);
    check_eq("rst_mrsp_ready", 64'(mem_rsp_ready_o),  64'd0);
    check_eq("rst_rsp_valid",  64'(core_rsp_valid_o), 64'd0);
    check_eq("rst_mreq_valid", 64'(mem_req_valid_o),  64'd0);
    check_eq("rst_mreq_addr",  64'(mem_req_addr_o),   64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check_eq("post_rst_req_ready",  64'(core_req_ready_o), 64'd1);
    check_eq("post_rst_mrsp_ready", 64'(mem_rsp_ready_o),  64'd1);
    tick();

    // cold miss, refill, next-cycle hit on the refilled set
    req(32'h1000, 3'd3, 2'b11, 1'b1);
    wait_mq(1);
    check_eq("cold_mreq_addr", 64'(mq[0].addr), 64'h1000);
    check_eq("cold_mreq_src",  64'(mq[0].src),  64'd0);
    refill(1'b1);
    req(32'h1008, 3'd3, 2'b11, 1'b0);
    idle(3);
    check_eq("hit_no_mreq", 64'(mq.size()), 64'd0);

    // merge three misses to one block, then overflow the table
    base = n_mreq;
    req(32'h2000, 3'd0, 2'b11, 1'b1);
    req(32'h2000, 3'd1, 2'b01, 1'b1);
    req(32'h2000, 3'd2, 2'b10, 1'b1);
    req(32'h2100, 3'd3, 2'b11, 1'b1);
    req(32'h2200, 3'd4, 2'b11, 1'b1);
    req(32'h2300, 3'd5, 2'b11, 1'b1);
    req(32'h2400, 3'd6, 2'b11, 1'b1);
    idle(10);
    check_eq("full_mreq_count", 64'(n_mreq - base), 64'd4);
    for (int i = 0; i < 4 && i < mq.size(); i++) begin
      check_eq("full_mreq_addr", 64'(mq[i].addr), 64'(32'h2000 + 32'(i) * 32'h100));
      check_eq("full_mreq_src",  64'(mq[i].src),  64'(i));
    end
    repeat (4) refill(1'b1);
    idle(3);

    // flush warp 2 while warp 5 is being accepted
    core_req_valid_i = 1'b1; core_req_addr_i = 32'h1010; core_req_wid_i = 3'd2; core_req_mask_i = 2'b11;
    @(negedge clk);
    check_eq("flush_victim_accept", 64'(core_req_ready_o), 64'd1);
    tick();
    core_req_addr_i = 32'h1000; core_req_wid_i = 3'd5;
    flush_valid_i = 1'b1; flush_wid_i = 3'd2;
    @(negedge clk);
    check_eq("flush_peer_accept", 64'(core_req_ready_o), 64'd1);
    sb.push_back('{addr: 32'h1000, wid: 3'd5, mask: 2'b11, status: 1'b0,
                   data: {memword(32'h1004), memword(32'h1000)}, acc: cyc});
    tick();
    core_req_valid_i = 1'b0; flush_valid_i = 1'b0;
    idle(4);

    // round-robin replacement in set 0 after a clean invalidate
    pulse_invalid();
    for (int i = 0; i < 5; i++) begin
      req(32'h4000 + 32'(i) * 32'h400, 3'(i), 2'b01, 1'b1);
      wait_mq(1);
      refill(1'b1);
    end
    for (int i = 1; i < 5; i++) req(32'h4000 + 32'(i) * 32'h400, 3'd0, 2'b10, 1'b0);
    req(32'h4000, 3'd0, 2'b11, 1'b1);
    wait_mq(1);
    refill(1'b1);
    idle(3);

    // stale refill after invalidate is dropped and the block re-misses
    req(32'h3000, 3'd1, 2'b11, 1'b1);
    wait_mq(1);
    pulse_invalid();
    refill(1'b0);
    req(32'h3000, 3'd1, 2'b11, 1'b1);
    wait_mq(1);
    check_eq("stale_remiss_addr", 64'(mq[0].addr), 64'h3000);
    refill(1'b1);
    req(32'h3008, 3'd1, 2'b11, 1'b0);
    idle(3);

    // memory backpressure holds the request stable
    mem_req_ready_i = 1'b0;
    req(32'h6000, 3'd4, 2'b11, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req_valid_o) break;
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("bp_valid", 64'(mem_req_valid_o),  64'd1);
      check_eq("bp_addr",  64'(mem_req_addr_o),   64'h6000);
      check_eq("bp_src",   64'(mem_req_source_o), 64'd0);
      tick();
    end
    mem_req_ready_i = 1'b1;
    wait_mq(1);

    // reset in the middle of a refill
    m = mq.pop_front();
    mem_rsp_valid_i = 1'b1; mem_rsp_source_i = m.src; mem_rsp_data_i = blockdata(m.addr);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_req_ready",  64'(core_req_ready_o),  64'd0);
    check_eq("mid_rst_mrsp_ready", 64'(mem_rsp_ready_o),   64'd0);
    check_eq("mid_rst_rsp_valid",  64'(core_rsp_valid_o),  64'd0);
    check_eq("mid_rst_rsp_status", 64'(core_rsp_status_o), 64'd0);
    check_eq("mid_rst_rsp_data",   core_rsp_data_o,        64'd0);
    check_eq("mid_rst_rsp_addr",   64'(core_rsp_addr_o),   64'd0);
    check_eq("mid_rst_mreq_valid", 64'(mem_req_valid_o),   64'd0);
    check_eq("mid_rst_mreq_addr",  64'(mem_req_addr_o),    64'd0);
    check_eq("mid_rst_mreq_src",   64'(mem_req_source_o),  64'd0);
    tick();
    mem_rsp_valid_i = 1'b0;
    rst_n = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b1;
    @(negedge clk);
    check_eq("late_rsp_ignored", 64'(core_req_ready_o), 64'd1);
    tick();
    mem_rsp_valid_i = 1'b0;
    req(32'h6000, 3'd4, 2'b11, 1'b1);
    wait_mq(1);
    check_eq("post_rst_mreq_addr", 64'(mq[0].addr), 64'h6000);
    check_eq("post_rst_mreq_src",  64'(mq[0].src),  64'd0);
    refill(1'b1);
    idle(5);

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    check_eq("mq_drained", 64'(mq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_sa_nb.md
Name: icache_sa_nb

Overview:
- Parametrised, non-blocking, set-associative instruction cache that sits between the warp scheduler/fetch stage and the next-level memory of an SM core.
- Generalises the single-configuration icache in four ways:
  - configurable ways, sets, block size, fetch width and warp count;
  - core-side ready/valid backpressure;
  - a merging miss table with a configurable number of entries;
  - epoch-tagged invalidation that discards stale refills.
- A hit returns data two cycles after acceptance. A miss returns status=1 so the core replays the fetch.

Parameters:
- XLEN, 32, address/word width
- NUM_WAYS, 4, associativity (power of 2, ≥2)
- NUM_SETS, 32, sets (power of 2)
- BLOCK_WORDS, 8, 32-bit words per block (power of 2)
- NUM_FETCH, 2, words returned per response (≤ BLOCK_WORDS)
- NUM_WARPS, 8, warps; WID_W = clog2(NUM_WARPS)
- MISS_ENTRIES, 4, miss-table entries (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- invalid_i  in  1  invalidate entire cache (1-cycle pulse)
- core_req_valid_i  in  1  fetch request
- core_req_ready_o  out  1  request accepted when valid&ready
- core_req_addr_i  in  XLEN  fetch PC (word aligned)
- core_req_mask_i  in  NUM_FETCH  per-word valid
- core_req_wid_i  in  WID_W  warp id
- flush_valid_i  in  1  flush in-flight requests of a warp
- flush_wid_i  in  WID_W  warp to flush
- core_rsp_valid_o  out  1  response valid (no backpressure)
- core_rsp_addr_o  out  XLEN  echoed PC
- core_rsp_data_o  out  NUM_FETCH*XLEN  words PC..PC+4*(NUM_FETCH-1); word 0 in LSBs
- core_rsp_mask_o  out  NUM_FETCH  echoed mask
- core_rsp_wid_o  out  WID_W  echoed warp id
- core_rsp_status_o  out  1  0 = hit, 1 = miss (replay)
- mem_req_valid_o  out  1  refill request
- mem_req_ready_i  in  1  memory accepts
- mem_req_addr_o  out  XLEN  block-aligned address
- mem_req_source_o  out  clog2(MISS_ENTRIES)  miss-table index
- mem_rsp_valid_i  in  1  refill data
- mem_rsp_ready_o  out  1  always 1 except during reset
- mem_rsp_source_i  in  clog2(MISS_ENTRIES)  echoed index
- mem_rsp_data_i  in  BLOCK_WORDS*XLEN  block data

Behaviour:
- **Address split:** offset = clog2(BLOCK_WORDS)+2 LSBs; set = next clog2(NUM_SETS) bits; tag = remainder. A fetch that crosses a block boundary returns wrapped words from the same block; the core guarantees alignment, so this case is not checked.
- **Pipeline:**
  - st0: accept; read tag/valid/data.
  - st1: compare tags, select way and words; on miss, probe/allocate the miss table.
  - st2: drive the response.
  - A request accepted at cycle T gives rsp_valid at T+2. Throughput is 1 per cycle.
- **core_req_ready_o** is 0 when any of the following hold:
  - a refill write occurs this cycle (single-port arrays; refill has priority);
  - invalid_i is asserted;
  - during reset.
- **Flush:** a request in st0 (accepting) or st1 whose wid equals flush_wid_i while flush_valid_i=1 is dropped. It produces no response and no miss-table allocation. The st2 output is not flushed.
- **Hit/miss:** hit when valid[set][w] && tag match for some w; at most one way matches. A miss responds with status=1 and data = don't-care.
- **Miss table:** MISS_ENTRIES entries, each holding {valid, issued, block addr, epoch}.
  - A miss to a block already present in the table merges: no new entry.
  - Otherwise the lowest free entry is allocated.
  - If the table is full, the miss is reported but not recorded.
  - Allocation and a same-cycle free of a different entry are both honoured.
  - A miss matching the entry freed in the same cycle allocates a fresh entry.
- **Memory request:** issues the lowest valid && !issued entry. mem_req_valid_o stays high and addr/source stay stable until ready; issued is set on fire. One request per cycle maximum.
- **Refill:** on mem_rsp fire:
  - the entry at source is freed;
  - if entry.epoch == current epoch, write tag+data into the round-robin victim way of the set, set valid, and advance that set's RR pointer (wraps NUM_WAYS-1 → 0);
  - if the epochs differ, the data is discarded;
  - a response to an invalid entry is accepted and ignored.
  - A refill to set S followed by a read of S in the next cycle must hit.
- **Invalidate:** in the cycle after invalid_i, all valid bits clear and the epoch toggles. Outstanding entries remain until their responses arrive. Requests already in st1/st2 complete with their looked-up result.
- **Reset:** all valid bits, RR pointers, miss table and epoch = 0. Outputs: core_rsp_valid_o=0, status=0, data/addr/mask/wid=0, mem_req_valid_o=0, mem_req_addr_o=0, mem_req_source_o=0, core_req_ready_o=0, mem_rsp_ready_o=0. Asserting reset mid-miss discards all state; any later mem_rsp is ignored as invalid-entry.

Test Plan:
- **Cold miss then hit:** req PC 0x1000 wid 3 at T → T+2 status=1; mem_req addr 0x1000 src 0. Respond with words 0..7 = 0xA0..0xA7, then re-request PC 0x1008 → T+2 status=0, data {0xA3,0xA2}.
- **Merge and full table:** 3 misses to 0x2000 plus 4 misses to distinct blocks (MISS_ENTRIES=4) → exactly 4 mem requests; the 5th distinct block gives no request; all responses have status=1.
- **Flush:** req wid 2 at T with flush_valid/wid=2 at T+1 → no response at T+2; a concurrent req from wid 5 still responds.
- **Replacement:** 5 distinct tags filled into set 0 (NUM_WAYS=4) → 5th evicts the first; the first re-misses while tags 2–5 hit.
- **Stale refill:** miss 0x3000, pulse invalid_i, then deliver the refill → entry freed, ready stays high, re-request of 0x3000 misses and a new mem_req is issued.
- **Backpressure and reset:** mem_req_ready_i=0 for 10 cycles → valid/addr held stable. Assert rst_n=0 mid-refill → all outputs 0; post-reset responses are ignored.
